// File: rtl/seq_shifter.sv
// Multi-cycle shifter: shifts a latched operand by up to STEP bits per clock
// (SLL, SRL, SRA, ROL) and pulses done when the result appears on data_out.
module seq_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam logic [SHW:0] STEP_K  = (SHW+1)'(STEP);
  localparam logic [SHW:0] WIDTH_K = (SHW+1)'(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] work;
  logic [1:0]       op;
  logic [SHW-1:0]   rem;

  logic [SHW:0]     k;
  logic [SHW:0]     rem_after;
  logic [WIDTH-1:0] shifted;

  // One step of the shift; k is never zero while in SHIFT.
  always_comb begin
    k         = ({1'b0, rem} < STEP_K) ? {1'b0, rem} : STEP_K;
    rem_after = {1'b0, rem} - k;
    shifted   = work;
    case (op)
      2'b00:   shifted = work << k;
      2'b01:   shifted = work >> k;
      2'b10:   shifted = $unsigned($signed(work) >>> k);
      default: shifted = (work << k) | (work >> (WIDTH_K - k));
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
      work     <= '0;
      op       <= 2'b00;
      rem      <= '0;
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            work <= data_in;
            op   <= mode;
            rem  <= shamt;
            if (shamt == '0) begin
              state    <= DONE;
              busy     <= 1'b0;
              done     <= 1'b1;
              data_out <= data_in;
            end else begin
              state <= SHIFT;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end
        end
        SHIFT: begin
          // start is ignored here; only the step counter drives progress
          work <= shifted;
          rem  <= rem_after[SHW-1:0];
          if (rem_after == '0) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            data_out <= shifted;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// Bench for seq_shifter: two instances (STEP=1 and STEP=4) exercised with
// directed cases and random operations against an arithmetic reference model.
module tb_seq_shifter;

  logic             clk;
  logic             rst_n;
  logic [1:0]       start;
  logic [1:0]       flush;
  logic [1:0][1:0]  mode;
  logic [1:0][4:0]  shamt;
  logic [1:0][31:0] data_in;
  logic [1:0]       busy;
  logic [1:0]       done;
  logic [1:0][31:0] data_out;
  logic [31:0]      last_out [2];

  int n_cmp = 0;
  int n_bad = 0;

  seq_shifter #(.WIDTH(32), .STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .flush(flush[0]),
    .mode(mode[0]), .shamt(shamt[0]), .data_in(data_in[0]),
    .busy(busy[0]), .done(done[0]), .data_out(data_out[0])
  );

  seq_shifter #(.WIDTH(32), .STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .flush(flush[1]),
    .mode(mode[1]), .shamt(shamt[1]), .data_in(data_in[1]),
    .busy(busy[1]), .done(done[1]), .data_out(data_out[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int step_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int lat_of(input int i, input int s);
    return (s + step_of(i) - 1) / step_of(i);
  endfunction

  // Reference result straight from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] m, input int s, input logic [31:0] d);
    logic [63:0] dd;
    case (m)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return d[31] ? ~((~d) >> s) : (d >> s);
      default: begin
        dd = {d, d} << s;
        return dd[63:32];
      end
    endcase
  endfunction

  // Drive a start for one edge; caller positions us away from the clock edge.
  task automatic issue(input int i, input logic [1:0] m, input int s, input logic [31:0] d);
    start[i]   = 1'b1;
    mode[i]    = m;
    shamt[i]   = 5'(s);
    data_in[i] = d;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  // Watch one operation: done after exactly lat edges, busy for lat cycles,
  // data_out frozen until done. Optionally pulses a stray start mid-shift.
  task automatic measure(input int i, input int lat, input logic [31:0] exp,
                         input int intrude_at, input string tag);
    int j = 0;
    int busy_cnt = 0;
    bit got = 0;
    bit moved = 0;
    while (j <= lat + 6) begin
      @(negedge clk);
      if (busy[i]) busy_cnt++;
      if (done[i]) begin
        got = 1;
        break;
      end
      if (data_out[i] !== last_out[i]) moved = 1;
      if (j == intrude_at) begin
        start[i]   = 1'b1;
        data_in[i] = 32'hFFFF_FFFF;
        mode[i]    = 2'($urandom_range(0, 3));
        shamt[i]   = 5'($urandom_range(0, 31));
      end
      if (j == intrude_at + 1) start[i] = 1'b0;
      j++;
    end
    start[i] = 1'b0;
    check({tag, " done_seen"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(j), 32'(lat));
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'(lat));
    check({tag, " held"}, 32'(moved), 32'd0);
    check({tag, " data"}, data_out[i], exp);
    $display("op %s inst=%0d lat=%0d result=%h", tag, i, j, data_out[i]);
    last_out[i] = exp;
  endtask

  task automatic run_op(input int i, input logic [1:0] m, input int s,
                        input logic [31:0] d, input logic [31:0] exp, input string tag);
    @(negedge clk);
    issue(i, m, s, d);
    measure(i, lat_of(i, s), exp, -1, tag);
  endtask

  initial begin
    logic [1:0]  m;
    logic [31:0] d;
    int          s;
    bit          seen;

    rst_n = 1'b0;
    start = '0;
    flush = '0;
    mode = '0;
    shamt = '0;
    data_in = '0;
    last_out[0] = '0;
    last_out[1] = '0;

    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("reset busy", 32'(busy[i]), 32'd0);
      check("reset done", 32'(done[i]), 32'd0);
      check("reset data", data_out[i], 32'd0);
    end
    rst_n = 1'b1;

    // Directed cases
    run_op(0, 2'b00, 2, 32'h0000_0001, 32'h0000_0004, "sll_s1");
    @(negedge clk);
    check("done_pulse_width", 32'(done[0]), 32'd0);
    run_op(1, 2'b10, 31, 32'h8000_0000, 32'hFFFF_FFFF, "sra31_s4");
    run_op(1, 2'b01, 31, 32'h8000_0000, 32'h0000_0001, "srl31_s4");
    run_op(1, 2'b11, 4, 32'h8000_0001, 32'h0000_0018, "rol4_s4");
    run_op(0, 2'b11, 4, 32'h8000_0001, 32'h0000_0018, "rol4_s1");
    run_op(0, 2'b10, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "zero_s1");
    run_op(1, 2'b01, 0, 32'h1234_5678, 32'h1234_5678, "zero_s4");

    // Stray start during shift must not disturb the running operation
    @(negedge clk);
    issue(0, 2'b00, 10, 32'h0000_0003);
    measure(0, 10, 32'h0000_0C00, 2, "ignore_start");

    // Flush (with a simultaneous start) aborts without done
    @(negedge clk);
    issue(0, 2'b01, 20, 32'hF0F0_F0F0);
    repeat (4) @(negedge clk);
    flush[0] = 1'b1;
    start[0] = 1'b1;
    shamt[0] = 5'd0;
    @(posedge clk);
    #1 flush[0] = 1'b0;
    start[0] = 1'b0;
    @(negedge clk);
    check("flush busy", 32'(busy[0]), 32'd0);
    check("flush done", 32'(done[0]), 32'd0);
    check("flush data", data_out[0], last_out[0]);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (done[0] || busy[0]) seen = 1;
    end
    check("flush quiet", 32'(seen), 32'd0);
    $display("op flush inst=0 data=%h", data_out[0]);

    // Back-to-back: second start accepted in the DONE cycle
    run_op(1, 2'b00, 9, 32'h0000_00FF, 32'h0001_FE00, "b2b_first");
    issue(1, 2'b11, 13, 32'hA5A5_0001);
    measure(1, 4, ref_shift(2'b11, 13, 32'hA5A5_0001), -1, "b2b_second");

    // Asynchronous reset between edges, mid-shift
    @(negedge clk);
    issue(0, 2'b00, 25, 32'h0000_0001);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("async_rst busy", 32'(busy[i]), 32'd0);
      check("async_rst done", 32'(done[i]), 32'd0);
      check("async_rst data", data_out[i], 32'd0);
      last_out[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (done[0]) seen = 1;
    end
    check("rst no_done", 32'(seen), 32'd0);
    $display("op async_reset inst=0 data=%h", data_out[0]);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 2'b00, 3, 32'h0000_0005);
    measure(0, 3, 32'h0000_0028, -1, "first_after_rst");

    // Random operations against the model, sometimes back-to-back
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int n = 0; n < 40; n++) begin
        m = 2'($urandom_range(0, 3));
        s = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 31));
        d = $urandom;
        if ($urandom_range(0, 3) != 0) @(negedge clk);
        issue(i, m, s, d);
        measure(i, lat_of(i, s), ref_shift(m, s, d), -1, "random");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
